// File: rtl/bist_stim_misr_if.sv
// rtl/bist_stim_misr_if.sv - control, stimulus and response signals of the BIST harness
interface bist_stim_misr_if;
    logic        start;
    logic        abort;
    logic [5:0]  resp;
    logic [2:0]  pat;
    logic        dut_rst;
    logic        busy;
    logic        done;
    logic [15:0] pat_cnt;
    logic [15:0] signature;
    logic        pass;

    modport master (
        output start, abort, resp,
        input  pat, dut_rst, busy, done, pat_cnt, signature, pass
    );

    modport slave (
        input  start, abort, resp,
        output pat, dut_rst, busy, done, pat_cnt, signature, pass
    );
endinterface

// File: rtl/bist_stim_misr.sv
// rtl/bist_stim_misr.sv - LFSR stimulus, MISR compaction and run sequencer; optional BIST_SIG_CMP_EN signature compare
module bist_stim_misr #(
    parameter int          NUM_PAT  = 256,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          RESP_LAT = 1,
    parameter logic [15:0] EXP_SIG  = 16'h0000
) (
    input logic               blif_clk_net,
    input logic               blif_reset_net,
    bist_stim_misr_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_PAT   = 16'(NUM_PAT - 1);
    localparam logic [2:0]  LAST_FLUSH = 3'(RESP_LAT - 1);

    state_t                state;
    state_t                state_n;
    logic [15:0]           lfsr;
    logic [15:0]           misr;
    logic [15:0]           misr_n;
    logic [15:0]           pat_cnt;
    logic [RESP_LAT-1:0]   pipe;
    logic [2:0]            flush_cnt;
    logic                  in_run;
    logic                  abort_hit;
    logic                  capture;
    logic                  lfsr_fb;
    logic                  misr_fb;
    logic                  busy_c;
    logic                  done_c;
    logic                  dut_rst_c;

    assign in_run    = (state == S_RUN);
    assign abort_hit = bus.abort && (state != S_IDLE);
    // An aborted run drops its in-flight responses, so the abort cycle never captures.
    assign capture   = pipe[RESP_LAT-1] && !abort_hit;
    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign misr_fb   = misr[15] ^ misr[13] ^ misr[12] ^ misr[10];
    assign misr_n    = capture ? ({misr[14:0], misr_fb} ^ {10'b0, bus.resp}) : misr;

    // State register.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and state-derived outputs; abort overrides every other transition.
    always_comb begin
        state_n   = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        dut_rst_c = 1'b1;
        case (state)
            S_IDLE: begin
                if (bus.start) state_n = S_INIT;
            end
            S_INIT: begin
                busy_c  = 1'b1;
                state_n = S_RUN;
            end
            S_RUN: begin
                busy_c    = 1'b1;
                dut_rst_c = 1'b0;
                if (pat_cnt == LAST_PAT) state_n = S_FLUSH;
            end
            S_FLUSH: begin
                busy_c    = 1'b1;
                dut_rst_c = 1'b0;
                if (flush_cnt == LAST_FLUSH) state_n = S_DONE;
            end
            S_DONE: begin
                done_c = 1'b1;
                if (bus.start) state_n = S_INIT;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort_hit) state_n = S_IDLE;
    end

    // Pattern generator, response compactor, pattern counter and capture pipe.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            lfsr      <= SEED;
            misr      <= 16'h0000;
            pat_cnt   <= 16'h0000;
            pipe      <= '0;
            flush_cnt <= 3'd0;
        end else if (state == S_INIT) begin
            lfsr      <= SEED;
            misr      <= 16'h0000;
            pat_cnt   <= 16'h0000;
            pipe      <= '0;
            flush_cnt <= 3'd0;
        end else begin
            if (in_run) begin
                lfsr    <= {lfsr[14:0], lfsr_fb};
                pat_cnt <= pat_cnt + 16'd1;
            end
            misr <= misr_n;
            if (abort_hit) begin
                pipe <= '0;
            end else begin
                pipe <= (pipe << 1) | RESP_LAT'(in_run);
            end
            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 3'd1 : 3'd0;
        end
    end

`ifdef BIST_SIG_CMP_EN
    logic pass_q;

    // Compare the final signature as DONE is entered; drops as soon as DONE is left.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= (state_n == S_DONE) && (misr_n == EXP_SIG);
        end
    end

    assign bus.pass = pass_q;
`else
    assign bus.pass = 1'b0;
`endif

    assign bus.pat       = lfsr[2:0];
    assign bus.dut_rst   = dut_rst_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.pat_cnt   = pat_cnt;
    assign bus.signature = misr;

endmodule
